// File: rtl/rv_fetch_req_if.sv
// Instruction-bus bundle between the fetch requester (master) and the bus (slave).
interface rv_fetch_req_if #(
  parameter int IADDR_SPACE_BITS = 16,
  parameter int WIDTH            = 32
);
  logic                        bus_req;
  logic [IADDR_SPACE_BITS-1:2] bus_addr;
  logic                        bus_ack;
  logic                        bus_rvalid;
  logic [WIDTH-1:0]            bus_rdata;

  modport master (output bus_req, bus_addr, input bus_ack, bus_rvalid, bus_rdata);
  modport slave  (input bus_req, bus_addr, output bus_ack, bus_rvalid, bus_rdata);
endinterface

// File: rtl/rv_fetch_req.sv
// Instruction-fetch requester: credit-limited bus reads, skid FIFO, redirect with stale-response kill.
// Optional stall counter enabled by defining FETCH_REQ_PERF_EN.
module rv_fetch_req #(
  parameter int IADDR_SPACE_BITS = 16,
  parameter int WIDTH            = 32,
  parameter int OUTST_BITS       = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [IADDR_SPACE_BITS-1:1] i_reset_pc,
  input  logic                        i_branch,
  input  logic [IADDR_SPACE_BITS-1:1] i_branch_pc,
  rv_fetch_req_if.master              bus,
  input  logic                        i_buf_not_full,
  output logic                        o_push,
  output logic [WIDTH-1:0]            o_data,
  output logic                        o_flush,
  output logic [IADDR_SPACE_BITS-1:1] o_flush_pc,
  output logic [31:0]                 o_perf_stall
);
  localparam int SKID = 2**OUTST_BITS;
  localparam int CW   = OUTST_BITS + 1;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_REDIR = 2'd2;

  logic [1:0]                  r_state;
  logic [IADDR_SPACE_BITS-1:2] r_fetch_addr;
  logic [IADDR_SPACE_BITS-1:1] r_pc;
  logic [CW-1:0]               r_live;
  logic [CW-1:0]               r_kill;
  logic [CW-1:0]               r_cnt;
  logic [OUTST_BITS-1:0]       r_head;
  logic [OUTST_BITS-1:0]       r_tail;
  logic [WIDTH-1:0]            r_skid [SKID];

  logic          w_run;
  logic [CW+1:0] w_used;
  logic          w_credit_ok;
  logic          w_issue;
  logic          w_kill_resp;
  logic          w_accept;
  logic          w_skid_empty;
  logic          w_block_push;
  logic          w_bypass;
  logic          w_pop;
  logic          w_wr;

  assign w_run        = (r_state == ST_RUN);
  assign w_used       = (CW+2)'(r_live) + (CW+2)'(r_kill) + (CW+2)'(r_cnt);
  assign w_credit_ok  = (w_used < (CW+2)'(SKID));
  assign w_issue      = !i_reset && w_run && !i_branch && w_credit_ok;
  assign w_kill_resp  = bus.bus_rvalid && (r_kill != '0);
  assign w_accept     = bus.bus_rvalid && (r_kill == '0);
  assign w_skid_empty = (r_cnt == '0);
  assign w_block_push = i_reset || i_branch || (r_state == ST_REDIR);

  assign bus.bus_req  = w_issue;
  assign bus.bus_addr = r_fetch_addr;
  assign o_flush      = i_reset || !w_run;
  assign o_flush_pc   = i_reset ? i_reset_pc : r_pc;

  // A queued word always goes out before a fresh one so delivery stays in request order.
  always_comb begin
    o_push = 1'b0;
    o_data = bus.bus_rdata;
    if (!w_block_push) begin
      if (!w_skid_empty) begin
        o_push = i_buf_not_full;
        o_data = r_skid[r_head];
      end else begin
        o_push = w_accept && i_buf_not_full;
      end
    end
  end

  assign w_bypass = !w_block_push && w_skid_empty && w_accept && i_buf_not_full;
  assign w_pop    = o_push && !w_skid_empty;
  assign w_wr     = w_accept && !w_bypass;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_INIT;
      r_fetch_addr <= i_reset_pc[IADDR_SPACE_BITS-1:2];
      r_pc         <= i_reset_pc;
      r_live       <= '0;
      r_kill       <= '0;
      r_cnt        <= '0;
      r_head       <= '0;
      r_tail       <= '0;
    end else if (i_branch) begin
      // Every response still owed to the old stream, minus one arriving now, must be dropped.
      r_state      <= ST_REDIR;
      r_fetch_addr <= i_branch_pc[IADDR_SPACE_BITS-1:2];
      r_pc         <= i_branch_pc;
      r_kill       <= r_live + r_kill - CW'(bus.bus_rvalid);
      r_live       <= '0;
      r_cnt        <= '0;
      r_head       <= '0;
      r_tail       <= '0;
    end else begin
      if (r_state != ST_RUN) r_state <= ST_RUN;
      if (w_issue && bus.bus_ack) r_fetch_addr <= r_fetch_addr + (IADDR_SPACE_BITS-2)'(1);
      r_live <= r_live + CW'(w_issue && bus.bus_ack) - CW'(w_accept);
      if (w_kill_resp) r_kill <= r_kill - CW'(1);
      if (w_pop) r_head <= r_head + OUTST_BITS'(1);
      if (w_wr) r_tail <= r_tail + OUTST_BITS'(1);
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr && !i_reset && !i_branch) r_skid[r_tail] <= bus.bus_rdata;
  end

  assert property (@(posedge i_clk) disable iff (i_reset)
    !(w_wr && !w_pop && !i_branch && (r_cnt == CW'(SKID))));

`ifdef FETCH_REQ_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_perf <= '0;
    end else if (w_run && !i_branch && !w_credit_ok && (r_perf != '1)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign o_perf_stall = r_perf;
`else
  assign o_perf_stall = '0;
`endif

endmodule

// File: tb/tb_rv_fetch_req.sv
// Randomized bench for rv_fetch_req: queue-based bus and fetch model predicts every output each cycle.
// Honours FETCH_REQ_PERF_EN for the expected stall counter.
module tb_rv_fetch_req;
  localparam int AW = 16;

  typedef enum int {M_INIT, M_RUN, M_REDIR} mode_t;
  typedef struct {logic [13:0] addr; bit stale;} flight_t;
  typedef struct {logic [13:0] addr; int ready;} busent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:1] resetPc;
  logic          branch;
  logic [AW-1:1] branchPc;
  logic          bufNotFull;
  logic          push;
  logic [31:0]   data;
  logic          flush;
  logic [AW-1:1] flushPc;
  logic [31:0]   perfStall;

  rv_fetch_req_if #(.IADDR_SPACE_BITS(AW), .WIDTH(32)) bus ();

  rv_fetch_req #(.IADDR_SPACE_BITS(AW), .WIDTH(32), .OUTST_BITS(2)) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_reset_pc(resetPc),
    .i_branch(branch),
    .i_branch_pc(branchPc),
    .bus(bus),
    .i_buf_not_full(bufNotFull),
    .o_push(push),
    .o_data(data),
    .o_flush(flush),
    .o_flush_pc(flushPc),
    .o_perf_stall(perfStall)
  );

  always #5 clk = ~clk;

  mode_t       mMode;
  logic [13:0] mFetch;
  logic [AW-1:1] mPc;
  flight_t     mFlight[$];
  logic [31:0] mSkid[$];
  logic [31:0] mPerf;
  busent_t     busQ[$];
  int          cycle;
  int          checks;
  int          fails;

  function automatic logic [31:0] wordData(input logic [13:0] a);
    return (32'h9E3779B9 * {18'd0, a}) ^ {a, 2'b01, a, 2'b10};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cycle, got, exp);
    end
  endtask

  // One clock: drive inputs after the edge, compare settled outputs, then advance the model.
  task automatic applyStimulus(input bit rst, input bit br, input logic [AW-1:1] bpc,
                               input bit ack, input bit bnf, input int rvPct, input int extraLat);
    bit          rv;
    logic [13:0] rvAddr;
    bit          credit, expReq, expPush, haveWord, fromSkid;
    logic [31:0] expData, wordVal, expPerf;
    flight_t     f;
    @(posedge clk);
    #1;
    cycle++;
    rv = 1'b0;
    rvAddr = '0;
    if (rst) begin
      busQ.delete();
    end else if (busQ.size() > 0 && busQ[0].ready <= cycle && int'($urandom_range(99)) < rvPct) begin
      rv = 1'b1;
      rvAddr = busQ[0].addr;
      void'(busQ.pop_front());
    end
    reset = rst;
    branch = br;
    branchPc = bpc;
    bus.bus_ack = ack;
    bufNotFull = bnf;
    bus.bus_rvalid = rv;
    bus.bus_rdata = rv ? wordData(rvAddr) : $urandom;
    #1;
    if (rst) begin
      checkOutput("rst_flush", 32'(flush), 32'd1);
      checkOutput("rst_flushPc", 32'(flushPc), 32'(resetPc));
      checkOutput("rst_req", 32'(bus.bus_req), 32'd0);
      checkOutput("rst_push", 32'(push), 32'd0);
      mMode = M_INIT;
      mFetch = resetPc[AW-1:2];
      mPc = resetPc;
      mFlight.delete();
      mSkid.delete();
      mPerf = '0;
      return;
    end
    credit = (mFlight.size() + mSkid.size()) < 4;
    expReq = (mMode == M_RUN) && !br && credit;
    haveWord = 1'b0;
    wordVal = '0;
    if (rv && mFlight.size() > 0) begin
      f = mFlight.pop_front();
      if (!f.stale) begin
        haveWord = 1'b1;
        wordVal = wordData(f.addr);
      end
    end
    expPush = 1'b0;
    expData = '0;
    fromSkid = 1'b0;
    if (!br && mMode != M_REDIR) begin
      if (mSkid.size() > 0) begin
        expPush = bnf;
        expData = mSkid[0];
        fromSkid = 1'b1;
      end else if (haveWord) begin
        expPush = bnf;
        expData = wordVal;
      end
    end
`ifdef FETCH_REQ_PERF_EN
    expPerf = mPerf;
`else
    expPerf = '0;
`endif
    checkOutput("flush", 32'(flush), 32'(mMode != M_RUN));
    checkOutput("flushPc", 32'(flushPc), 32'(mPc));
    checkOutput("req", 32'(bus.bus_req), 32'(expReq));
    if (expReq) checkOutput("addr", 32'(bus.bus_addr), 32'(mFetch));
    checkOutput("push", 32'(push), 32'(expPush));
    if (expPush) checkOutput("data", data, expData);
    checkOutput("perf", perfStall, expPerf);
    if (br) begin
      foreach (mFlight[i]) mFlight[i].stale = 1'b1;
      mSkid.delete();
      mPc = bpc;
      mFetch = bpc[AW-1:2];
      mMode = M_REDIR;
    end else begin
      if (mMode == M_RUN && !credit && mPerf != '1) mPerf = mPerf + 32'd1;
      if (expPush && fromSkid) void'(mSkid.pop_front());
      if (haveWord && !(expPush && !fromSkid)) mSkid.push_back(wordVal);
      if (expReq && ack) begin
        mFlight.push_back('{mFetch, 1'b0});
        busQ.push_back('{mFetch, cycle + 2 + extraLat});
        mFetch = mFetch + 14'd1;
      end
      mMode = M_RUN;
    end
  endtask

  initial begin
    bit          r;
    logic [31:0] rnd;
    checks = 0;
    fails = 0;
    cycle = 0;
    reset = 1'b1;
    resetPc = 15'h0040;
    branch = 1'b0;
    branchPc = '0;
    bufNotFull = 1'b1;
    bus.bus_ack = 1'b0;
    bus.bus_rvalid = 1'b0;
    bus.bus_rdata = '0;

    $display("[TB] reset and straight-line fetch");
    applyStimulus(1, 0, '0, 1, 1, 100, 0);
    applyStimulus(1, 0, '0, 1, 1, 100, 0);
    repeat (16) applyStimulus(0, 0, '0, 1, 1, 100, 0);

    $display("[TB] buffer full, skid fills");
    repeat (10) applyStimulus(0, 0, '0, 1, 0, 100, 0);
    repeat (8) applyStimulus(0, 0, '0, 1, 1, 100, 0);

    $display("[TB] redirect with responses in flight");
    applyStimulus(0, 1, 15'h0103, 1, 1, 100, 1);
    repeat (8) applyStimulus(0, 0, '0, 1, 1, 100, 1);

    $display("[TB] back-to-back redirects");
    applyStimulus(0, 1, 15'h0010, 1, 1, 100, 0);
    applyStimulus(0, 1, 15'h0200, 1, 1, 100, 0);
    repeat (8) applyStimulus(0, 0, '0, 1, 1, 100, 0);

    $display("[TB] fetch address wrap");
    applyStimulus(0, 1, 15'h7FFC, 1, 1, 100, 0);
    repeat (6) applyStimulus(0, 0, '0, 1, 1, 100, 0);

    $display("[TB] credit stall with buffer held full");
    repeat (12) applyStimulus(0, 0, '0, 1, 0, 100, 0);
    repeat (6) applyStimulus(0, 0, '0, 1, 1, 100, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(199) == 0);
      if (r) begin
        rnd = $urandom;
        resetPc = rnd[14:0];
      end
      rnd = $urandom;
      applyStimulus(r, $urandom_range(29) == 0, rnd[14:0],
                    $urandom_range(99) < 70, $urandom_range(99) < 70, 60, int'($urandom_range(3)));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
